i2s_rx_deserializer: RTL

- I2S slave receiver at the input side of the equalizer.
- Deserializes the external ADC stream (bclk, lrclk, sdata) into stereo 24-bit signed samples.
- Emits a one-clk `sample_valid` strobe per complete stereo frame; this strobe drives the `enable` of the downstream FIR bank.
- All I2S lines are asynchronous to `clk`. They are oversampled and synchronized inside the block.

---
 rtl/i2s_rx_deserializer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S slave receiver: oversamples bclk/lrclk/sdata on clk and deserializes them into
// stereo signed samples, with a one-clk strobe per complete left+right frame.
module i2s_rx_deserializer #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic signed [WIDTH-1:0] left_out,
  output logic signed [WIDTH-1:0] right_out,
  output logic                    sample_valid,
  output logic                    frame_err
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   bclk_d;
  logic                   rise;
  logic                   rise_q;
  logic                   ws_q;
  logic                   sd_q;

  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_acc;
  logic [WIDTH-1:0] shreg_reg, shreg_next, shreg_acc;
  logic [WIDTH-1:0] lbuf_reg, lbuf_next;
  logic             lbuf_valid_reg, lbuf_valid_next;
  logic             armed_reg, armed_next;
  logic             ws_prev_reg, ws_prev_next;
  logic [WIDTH-1:0] left_next, right_next;
  logic             valid_next, err_next;

  assign rise = bclk_sync[SYNC_STAGES-1] & ~bclk_d;

  // Edge detect is registered together with ws/sd so all three stay coherent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_sync <= '0;
      ws_sync   <= '0;
      sd_sync   <= '0;
      bclk_d    <= 1'b0;
      rise_q    <= 1'b0;
      ws_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
      ws_sync   <= {ws_sync[SYNC_STAGES-2:0], i2s_lrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], i2s_sdata};
      bclk_d    <= bclk_sync[SYNC_STAGES-1];
      rise_q    <= rise;
      ws_q      <= ws_sync[SYNC_STAGES-1];
      sd_q      <= sd_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    cnt_next        = cnt_reg;
    shreg_next      = shreg_reg;
    cnt_acc         = cnt_reg;
    shreg_acc       = shreg_reg;
    lbuf_next       = lbuf_reg;
    lbuf_valid_next = lbuf_valid_reg;
    armed_next      = armed_reg;
    ws_prev_next    = ws_prev_reg;
    left_next       = left_out;
    right_next      = right_out;
    valid_next      = 1'b0;
    err_next        = 1'b0;

    if (!enable) begin
      armed_next      = 1'b0;
      cnt_next        = '0;
      shreg_next      = '0;
      lbuf_valid_next = 1'b0;
      // Track ws while idle so re-enabling mid-slot does not look like a slot edge.
      if (rise_q) ws_prev_next = ws_q;
    end else if (rise_q) begin
      if (armed_reg) begin
        if (cnt_reg < CNT_FULL) shreg_acc = {shreg_reg[WIDTH-2:0], sd_q};
        if (cnt_reg != CNT_MAX) cnt_acc = cnt_reg + CNT_W'(1);
      end
      cnt_next   = cnt_acc;
      shreg_next = shreg_acc;

      if (ws_q != ws_prev_reg) begin
        if (!armed_reg) begin
          armed_next = 1'b1;
        end else if (cnt_acc >= CNT_FULL) begin
          if (!ws_prev_reg) begin
            lbuf_next       = shreg_acc;
            lbuf_valid_next = 1'b1;
          end else if (lbuf_valid_reg) begin
            left_next       = lbuf_reg;
            right_next      = shreg_acc;
            valid_next      = 1'b1;
            lbuf_valid_next = 1'b0;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          err_next = 1'b1;
          if (!ws_prev_reg) lbuf_valid_next = 1'b0;
        end
        cnt_next     = '0;
        shreg_next   = '0;
        ws_prev_next = ws_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg        <= '0;
      shreg_reg      <= '0;
      lbuf_reg       <= '0;
      lbuf_valid_reg <= 1'b0;
      armed_reg      <= 1'b0;
      ws_prev_reg    <= 1'b0;
      left_out       <= '0;
      right_out      <= '0;
      sample_valid   <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      shreg_reg      <= shreg_next;
      lbuf_reg       <= lbuf_next;
      lbuf_valid_reg <= lbuf_valid_next;
      armed_reg      <= armed_next;
      ws_prev_reg    <= ws_prev_next;
      left_out       <= left_next;
      right_out      <= right_next;
      sample_valid   <= valid_next;
      frame_err      <= err_next;
    end
  end

endmodule
